vrf_write_sched: RTL and testbench
==================================

Name: vrf_write_sched

Overview:
- Write-port scheduler and hazard scoreboard for the 32 x 256-bit vector register file.
- Arbitrates the single RF write port (write-enable, 5-bit address, 256-bit data) between the vector ALU writeback and the data-memory load return. Both use a valid/ready handshake.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards until the pending write has landed.

Parameters:
- NUM_REGS, 32, number of vector registers.
- REG_WIDTH, 256, register/data width.
- ADDR_W, 5, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  REG_WIDTH  ALU result.
- alu_ready  out  1  ALU request granted this cycle.
- mem_valid  in  1  load-return request.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  REG_WIDTH  load data.
- mem_ready  out  1  load request granted this cycle.
- rf_we  out  1  to RF WE3.
- rf_addr  out  ADDR_W  to RF A3.
- rf_wd  out  REG_WIDTH  to RF WD3.
- iss_valid  in  1  instruction presented at issue.
- iss_rd  in  ADDR_W  destination to reserve.
- iss_rs1  in  ADDR_W  source 1.
- iss_rs2  in  ADDR_W  source 2.
- iss_use_rs2  in  1  rs2 is a real operand.
- iss_stall  out  1  hazard; do not issue this cycle.
- busy_vec  out  NUM_REGS  scoreboard bits, bit i = register i pending.
- err_unres  out  1  sticky: a write landed on a non-busy register.

Behaviour:
- Reset (rst_n low, async): rf_we=0, rf_addr=0, rf_wd=0, busy_vec=0, err_unres=0, RR pointer=ALU. A reset mid-operation discards all pending reservations and any queued write.
- Arbitration is combinational and round-robin.
  - Only one valid: that requester is granted.
  - Both valid: the requester the pointer favours is granted; the pointer then flips to the other requester.
  - The pointer updates only on a contested grant.
  - ready = grant; a handshake completes when valid && ready in the same cycle.
  - The RF write port always accepts, so one request is granted every cycle at most; requests never wait behind a full stage.
- Output stage: registered.
  - Grant at edge N -> rf_we=1 with the granted addr/data for exactly cycle N+1 (latency 1).
  - No grant -> rf_we=0; rf_addr and rf_wd hold their last values.
- Scoreboard:
  - Set: busy[iss_rd] <= 1 at the edge where iss_valid && !iss_stall.
  - Clear: busy[rf_addr] <= 0 at the edge where rf_we=1, i.e. the same edge the RF captures the data.
  - Set and clear on the same register at the same edge: set wins (new reservation).
- iss_stall = iss_valid && (busy[iss_rs1] || (iss_use_rs2 && busy[iss_rs2]) || busy[iss_rd]).
  - No bypass: a register being cleared this cycle still stalls, because the RF holds old data until the edge.
  - iss_stall = 0 when iss_valid = 0.
- err_unres is set at an edge where rf_we=1 and busy[rf_addr]=0. It clears only on reset. The write is still performed.
- All NUM_REGS registers are writable; there is no hardwired zero register.

Optional Feature:
- Macro: VRF_SCHED_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_conflict_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_stall_cnt increments each cycle iss_stall=1.
  - perf_conflict_cnt increments each cycle alu_valid && mem_valid.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single ALU write: issue rd=5 (busy_vec[5]=1); alu_valid, addr=5, data=A. Required: alu_ready same cycle; rf_we=1, rf_addr=5, rf_wd=A next cycle; busy_vec[5]=0 after that edge.
- Conflict: alu_valid and mem_valid held for 4 cycles with addrs 6/7 (both reserved). Required grants ALU, MEM, ALU, MEM; rf_addr sequence 6, 7, 6, 7.
- RAW hazard: rd=7 reserved, then issue rs1=7. Required: iss_stall=1 through the cycle rf_we writes reg 7; iss_stall=0 the following cycle.
- Set/clear collision: rf_we writes reg 9 at the same edge a new issue reserves rd=9. Required: busy_vec[9]=1 afterwards.
- Unreserved write: mem write to reg 3 with busy_vec[3]=0. Required: rf_we=1 for reg 3 and err_unres=1, sticky.
- Async reset: assert rst_n low mid-burst with busy_vec=0x000000E0. Required immediately: busy_vec=0, rf_we=0, err_unres=0; first contested grant after release goes to ALU.

Source files
------------

// File: rtl/vrf_write_sched_if.sv
// RF write-port bundle: ALU writeback request, load-return request and the RF write port.
// The scheduler sits on the slave side; requesters and the RF model sit on the master side.
interface vrf_write_sched_if #(
  parameter int ADDR_W    = 5,
  parameter int REG_WIDTH = 256
);
  logic                 alu_valid;
  logic [ADDR_W-1:0]    alu_addr;
  logic [REG_WIDTH-1:0] alu_data;
  logic                 alu_ready;
  logic                 mem_valid;
  logic [ADDR_W-1:0]    mem_addr;
  logic [REG_WIDTH-1:0] mem_data;
  logic                 mem_ready;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_addr;
  logic [REG_WIDTH-1:0] rf_wd;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_addr, rf_wd
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, rf_we, rf_addr, rf_wd
  );
endinterface

// File: rtl/vrf_write_sched.sv
// Vector RF write-port round-robin scheduler with per-register busy scoreboard.
// Optional VRF_SCHED_PERF_EN adds stall and request-conflict counters.
module vrf_write_sched #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 256,
  parameter int ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  vrf_write_sched_if.slave    wp,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic [ADDR_W-1:0]   iss_rs2,
  input  logic                iss_use_rs2,
  output logic                iss_stall,
  output logic [NUM_REGS-1:0] busy_vec,
`ifdef VRF_SCHED_PERF_EN
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_conflict_cnt,
`endif
  output logic                err_unres
);

  localparam logic RR_ALU = 1'b0;
  localparam logic RR_MEM = 1'b1;

  logic                 rr_q, rr_d;
  logic                 rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]    rf_addr_q, rf_addr_d;
  logic [REG_WIDTH-1:0] rf_wd_q, rf_wd_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 grant_alu, grant_mem, contested;

  assign contested = wp.alu_valid && wp.mem_valid;
  assign grant_alu = wp.alu_valid && (!wp.mem_valid || rr_q == RR_ALU);
  assign grant_mem = wp.mem_valid && (!wp.alu_valid || rr_q == RR_MEM);

  // Stall looks at the registered scoreboard only: the RF still holds old data
  // during the cycle its pending write is on the port.
  assign iss_stall = iss_valid && (busy_q[iss_rs1] ||
                                   (iss_use_rs2 && busy_q[iss_rs2]) ||
                                   busy_q[iss_rd]);

  always_comb begin
    rr_d      = contested ? ~rr_q : rr_q;
    rf_we_d   = grant_alu || grant_mem;
    rf_addr_d = rf_addr_q;
    rf_wd_d   = rf_wd_q;
    if (grant_alu) begin
      rf_addr_d = wp.alu_addr;
      rf_wd_d   = wp.alu_data;
    end else if (grant_mem) begin
      rf_addr_d = wp.mem_addr;
      rf_wd_d   = wp.mem_data;
    end

    // Clear first so a same-edge reservation of the same register wins.
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_addr_q] = 1'b0;
    if (iss_valid && !iss_stall) busy_d[iss_rd] = 1'b1;

    err_d = err_q || (rf_we_q && !busy_q[rf_addr_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= RR_ALU;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_wd_q   <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_wd_q   <= rf_wd_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wp.alu_ready = grant_alu;
  assign wp.mem_ready = grant_mem;
  assign wp.rf_we     = rf_we_q;
  assign wp.rf_addr   = rf_addr_q;
  assign wp.rf_wd     = rf_wd_q;
  assign busy_vec     = busy_q;
  assign err_unres    = err_q;

`ifdef VRF_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] conf_cnt_q, conf_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, iss_stall};
    conf_cnt_d  = conf_cnt_q + {31'd0, contested};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      conf_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      conf_cnt_q  <= conf_cnt_d;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_vrf_write_sched.sv
// Directed bench for vrf_write_sched: handshake/latency, round-robin, scoreboard hazards,
// set/clear collision, unreserved-write error and asynchronous reset.
module tb_vrf_write_sched;
  localparam int NR = 32;
  localparam int RW = 256;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic          iss_use_rs2;
  logic          iss_stall;
  logic [NR-1:0] busy_vec;
  logic          err_unres;
`ifdef VRF_SCHED_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_conflict_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [RW-1:0] DA = {8{32'hA5A5_0001}};
  localparam logic [RW-1:0] DB = {8{32'hB0B0_0002}};
  localparam logic [RW-1:0] DC = {8{32'hC0C0_0003}};
  localparam logic [RW-1:0] DD = {8{32'hD0D0_0004}};
  localparam logic [RW-1:0] DE = {8{32'hE0E0_0005}};
  localparam logic [RW-1:0] DF = {8{32'hF0F0_0006}};

  vrf_write_sched_if #(.ADDR_W(AW), .REG_WIDTH(RW)) wp ();

  vrf_write_sched #(.NUM_REGS(NR), .REG_WIDTH(RW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wp          (wp),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_use_rs2 (iss_use_rs2),
    .iss_stall   (iss_stall),
    .busy_vec    (busy_vec),
`ifdef VRF_SCHED_PERF_EN
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .err_unres   (err_unres)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wp.alu_valid = 1'b0; wp.alu_addr = '0; wp.alu_data = '0;
    wp.mem_valid = 1'b0; wp.mem_addr = '0; wp.mem_data = '0;
    iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; iss_use_rs2 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", RW'(busy_vec), '0);
    chk("rst_err",  RW'(err_unres), '0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic reserve(input logic [AW-1:0] rd);
    iss_valid = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0; iss_use_rs2 = 1'b0;
    step();
    iss_valid = 1'b0;
  endtask

  logic [AW-1:0] exp_addr [4];
  logic [RW-1:0] exp_data [4];
  logic          exp_alu  [4];

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk("reset_rf_we",   RW'(wp.rf_we),   '0);
    chk("reset_rf_addr", RW'(wp.rf_addr), '0);
    chk("reset_rf_wd",   wp.rf_wd,        '0);
    chk("reset_busy",    RW'(busy_vec),   '0);
    chk("reset_err",     RW'(err_unres),  '0);
    chk("idle_no_stall", RW'(iss_stall),  '0);
    rst_n = 1'b1;
    step();

    // Single ALU write to reserved r5
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 chk("t1_issue_stall", RW'(iss_stall), '0);
    step();
    iss_valid = 1'b0;
    chk("t1_busy_set", RW'(busy_vec), RW'(32'h0000_0020));
    wp.alu_valid = 1'b1; wp.alu_addr = 5'd5; wp.alu_data = DA;
    #1;
    chk("t1_alu_ready", RW'(wp.alu_ready), RW'(1));
    chk("t1_mem_ready", RW'(wp.mem_ready), '0);
    step();
    wp.alu_valid = 1'b0;
    chk("t1_rf_we",   RW'(wp.rf_we),   RW'(1));
    chk("t1_rf_addr", RW'(wp.rf_addr), RW'(5));
    chk("t1_rf_wd",   wp.rf_wd,        DA);
    chk("t1_busy_before_land", RW'(busy_vec), RW'(32'h0000_0020));
    step();
    chk("t1_rf_we_off",  RW'(wp.rf_we),   '0);
    chk("t1_addr_hold",  RW'(wp.rf_addr), RW'(5));
    chk("t1_wd_hold",    wp.rf_wd,        DA);
    chk("t1_busy_clear", RW'(busy_vec),   '0);
    chk("t1_err_clean",  RW'(err_unres),  '0);

    // Contested requests: r6 from ALU, r7 from load, held four cycles
    reserve(5'd6);
    reserve(5'd7);
    chk("t2_busy", RW'(busy_vec), RW'(32'h0000_00C0));
    exp_alu[0] = 1'b1; exp_alu[1] = 1'b0; exp_alu[2] = 1'b1; exp_alu[3] = 1'b0;
    exp_addr[0] = 5'd6; exp_addr[1] = 5'd7; exp_addr[2] = 5'd6; exp_addr[3] = 5'd7;
    exp_data[0] = DB; exp_data[1] = DC; exp_data[2] = DB; exp_data[3] = DC;
    wp.alu_valid = 1'b1; wp.alu_addr = 5'd6; wp.alu_data = DB;
    wp.mem_valid = 1'b1; wp.mem_addr = 5'd7; wp.mem_data = DC;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_alu_ready_%0d", i), RW'(wp.alu_ready), RW'(exp_alu[i]));
      chk($sformatf("t2_mem_ready_%0d", i), RW'(wp.mem_ready), RW'(!exp_alu[i]));
      step();
      chk($sformatf("t2_rf_addr_%0d", i), RW'(wp.rf_addr), RW'(exp_addr[i]));
      chk($sformatf("t2_rf_wd_%0d", i),   wp.rf_wd,        exp_data[i]);
    end
    idle_inputs();
    // The third write (r6 again) landed on an already-cleared register
    chk("t2_err_rewrite", RW'(err_unres), RW'(1));
    step();
    chk("t2_busy_final", RW'(busy_vec), '0);

    do_reset();
    step();

    // RAW hazard on r7
    reserve(5'd7);
    iss_valid = 1'b1; iss_rd = 5'd8; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
    #1 chk("t3_stall_a", RW'(iss_stall), RW'(1));
    step();
    chk("t3_stall_b", RW'(iss_stall), RW'(1));
    wp.mem_valid = 1'b1; wp.mem_addr = 5'd7; wp.mem_data = DD;
    #1 chk("t3_mem_ready", RW'(wp.mem_ready), RW'(1));
    step();
    wp.mem_valid = 1'b0;
    chk("t3_rf_we_r7",   RW'(wp.rf_we),   RW'(1));
    chk("t3_rf_addr_r7", RW'(wp.rf_addr), RW'(7));
    chk("t3_stall_during_write", RW'(iss_stall), RW'(1));
    step();
    chk("t3_stall_released", RW'(iss_stall), '0);
    chk("t3_busy_clear", RW'(busy_vec), '0);
    iss_rs1 = 5'd2; iss_rs2 = 5'd8; iss_use_rs2 = 1'b1;
    step();
    iss_valid = 1'b0;
    chk("t3_rd8_reserved", RW'(busy_vec), RW'(32'h0000_0100));
    chk("t3_err_clean", RW'(err_unres), '0);

    // Unreserved load return to r3
    wp.mem_valid = 1'b1; wp.mem_addr = 5'd3; wp.mem_data = DF;
    #1 chk("t5_mem_only_granted", RW'(wp.mem_ready), RW'(1));
    step();
    wp.mem_valid = 1'b0;
    chk("t5_rf_we",   RW'(wp.rf_we),   RW'(1));
    chk("t5_rf_addr", RW'(wp.rf_addr), RW'(3));
    chk("t5_rf_wd",   wp.rf_wd,        DF);
    step();
    chk("t5_err_set", RW'(err_unres), RW'(1));
    step();
    chk("t5_err_sticky", RW'(err_unres), RW'(1));

    // Set/clear collision on r9: write lands as a new reservation of r9 issues
    wp.alu_valid = 1'b1; wp.alu_addr = 5'd9; wp.alu_data = DE;
    step();
    wp.alu_valid = 1'b0;
    chk("t4_rf_addr", RW'(wp.rf_addr), RW'(9));
    iss_valid = 1'b1; iss_rd = 5'd9; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_use_rs2 = 1'b0;
    #1 chk("t4_issue_ok", RW'(iss_stall), '0);
    step();
    iss_valid = 1'b0;
    chk("t4_set_wins", RW'(busy_vec), RW'(32'h0000_0300));

    // Asynchronous reset in the middle of a contested burst
    do_reset();
    step();
    reserve(5'd5);
    reserve(5'd6);
    reserve(5'd7);
    chk("t6_busy_e0", RW'(busy_vec), RW'(32'h0000_00E0));
    wp.alu_valid = 1'b1; wp.alu_addr = 5'd5; wp.alu_data = DA;
    wp.mem_valid = 1'b1; wp.mem_addr = 5'd6; wp.mem_data = DB;
    step();
    chk("t6_burst_we", RW'(wp.rf_we), RW'(1));
    chk("t6_ptr_to_mem", RW'(wp.mem_ready), RW'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",    RW'(busy_vec),   '0);
    chk("t6_rst_rf_we",   RW'(wp.rf_we),   '0);
    chk("t6_rst_err",     RW'(err_unres),  '0);
    chk("t6_rst_rf_addr", RW'(wp.rf_addr), '0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_alu_first",     RW'(wp.alu_ready), RW'(1));
    chk("t6_mem_not_first", RW'(wp.mem_ready), '0);
    step();
    chk("t6_rf_addr_alu", RW'(wp.rf_addr), RW'(5));
    chk("t6_rf_wd_alu",   wp.rf_wd,        DA);
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
